// File: rtl/cpu_pkg.sv
// Shared CPU encodings: opcodes, ALU function codes, IR field positions and
// sequencer state codes used by both the control unit and the datapath/ALU.
package cpu_pkg;

  localparam int unsigned IR_W      = 32;
  localparam int unsigned REG_IDX_W = 4;
  localparam int unsigned ALUOP_W   = 4;

  localparam int unsigned OP_MSB = 31;
  localparam int unsigned RA_MSB = 26;
  localparam int unsigned RA_LSB = 23;
  localparam int unsigned RB_MSB = 22;
  localparam int unsigned RB_LSB = 19;
  localparam int unsigned RC_MSB = 18;
  localparam int unsigned RC_LSB = 15;

  localparam int unsigned OP_ADD  = 3;
  localparam int unsigned OP_SUB  = 4;
  localparam int unsigned OP_AND  = 5;
  localparam int unsigned OP_OR   = 6;
  localparam int unsigned OP_ROR  = 7;
  localparam int unsigned OP_ROL  = 8;
  localparam int unsigned OP_SHR  = 9;
  localparam int unsigned OP_SHRA = 10;
  localparam int unsigned OP_SHL  = 11;
  localparam int unsigned OP_DIV  = 15;
  localparam int unsigned OP_MUL  = 16;
  localparam int unsigned OP_NEG  = 17;
  localparam int unsigned OP_NOT  = 18;
  localparam int unsigned OP_NOP  = 26;
  localparam int unsigned OP_HALT = 27;

  typedef logic [ALUOP_W-1:0] aluop_t;

  localparam aluop_t ALU_ADD  = 4'd0;
  localparam aluop_t ALU_SUB  = 4'd1;
  localparam aluop_t ALU_AND  = 4'd2;
  localparam aluop_t ALU_OR   = 4'd3;
  localparam aluop_t ALU_SHR  = 4'd4;
  localparam aluop_t ALU_SHL  = 4'd5;
  localparam aluop_t ALU_SHRA = 4'd6;
  localparam aluop_t ALU_ROR  = 4'd7;
  localparam aluop_t ALU_ROL  = 4'd8;
  localparam aluop_t ALU_NEG  = 4'd9;
  localparam aluop_t ALU_NOT  = 4'd10;

  typedef logic [3:0] state_t;

  localparam state_t S_RESET = 4'd0;
  localparam state_t S_T0    = 4'd1;
  localparam state_t S_T1    = 4'd2;
  localparam state_t S_T2    = 4'd3;
  localparam state_t S_T3    = 4'd4;
  localparam state_t S_T4    = 4'd5;
  localparam state_t S_T5    = 4'd6;
  localparam state_t S_T6    = 4'd7;
  localparam state_t S_HALT  = 4'd8;

  typedef enum logic [2:0] {
    CLS_ALU3,
    CLS_MULDIV,
    CLS_UNARY,
    CLS_NOP,
    CLS_HALT
  } instr_class_e;

  typedef logic [REG_IDX_W-1:0] reg_idx_t;

  typedef struct packed {
    instr_class_e cls;
    aluop_t       alu_op;
    logic         mul;
    logic         div;
    reg_idx_t     ra;
    reg_idx_t     rb;
    reg_idx_t     rc;
  } decode_t;

endpackage

// File: rtl/instr_decoder.sv
// Combinational instruction decode: IR -> instruction class, ALU function,
// multiply/divide select and register fields. Unknown opcodes decode as nop.
module instr_decoder
  import cpu_pkg::*;
#(
  parameter int unsigned OPW = 5
) (
  input  logic [IR_W-1:0] IR,
  output decode_t         dec_c
);

  logic [OPW-1:0] op;
  logic           unused_ir_bits;

  assign op             = IR[OP_MSB -: OPW];
  assign unused_ir_bits = ^IR[RC_LSB-1:0];

  always_comb begin
    dec_c        = '0;
    dec_c.cls    = CLS_NOP;
    dec_c.alu_op = ALU_ADD;
    dec_c.ra     = IR[RA_MSB:RA_LSB];
    dec_c.rb     = IR[RB_MSB:RB_LSB];
    dec_c.rc     = IR[RC_MSB:RC_LSB];
    case (op)
      OPW'(OP_ADD):  begin dec_c.cls = CLS_ALU3;   dec_c.alu_op = ALU_ADD;  end
      OPW'(OP_SUB):  begin dec_c.cls = CLS_ALU3;   dec_c.alu_op = ALU_SUB;  end
      OPW'(OP_AND):  begin dec_c.cls = CLS_ALU3;   dec_c.alu_op = ALU_AND;  end
      OPW'(OP_OR):   begin dec_c.cls = CLS_ALU3;   dec_c.alu_op = ALU_OR;   end
      OPW'(OP_ROR):  begin dec_c.cls = CLS_ALU3;   dec_c.alu_op = ALU_ROR;  end
      OPW'(OP_ROL):  begin dec_c.cls = CLS_ALU3;   dec_c.alu_op = ALU_ROL;  end
      OPW'(OP_SHR):  begin dec_c.cls = CLS_ALU3;   dec_c.alu_op = ALU_SHR;  end
      OPW'(OP_SHRA): begin dec_c.cls = CLS_ALU3;   dec_c.alu_op = ALU_SHRA; end
      OPW'(OP_SHL):  begin dec_c.cls = CLS_ALU3;   dec_c.alu_op = ALU_SHL;  end
      OPW'(OP_DIV):  begin dec_c.cls = CLS_MULDIV; dec_c.div    = 1'b1;     end
      OPW'(OP_MUL):  begin dec_c.cls = CLS_MULDIV; dec_c.mul    = 1'b1;     end
      OPW'(OP_NEG):  begin dec_c.cls = CLS_UNARY;  dec_c.alu_op = ALU_NEG;  end
      OPW'(OP_NOT):  begin dec_c.cls = CLS_UNARY;  dec_c.alu_op = ALU_NOT;  end
      OPW'(OP_HALT): dec_c.cls = CLS_HALT;
      default:       dec_c.cls = CLS_NOP;
    endcase
  end

endmodule

// File: rtl/alu_control_sequencer.sv
// Hardwired T-state sequencer for fetch and the register-register ALU class.
// Strobes are a Moore decode of the state register (plus IR fields), so clear zeroes them at once.
module alu_control_sequencer
  import cpu_pkg::*;
#(
  parameter int unsigned NREGS = 16,
  parameter int unsigned OPW   = 5
) (
  input  logic              clock,
  input  logic              clear,
  input  logic [IR_W-1:0]   IR,
  output logic [NREGS-1:0]  Rin,
  output logic [NREGS-1:0]  Rout,
  output logic              PCin,
  output logic              PCout,
  output logic              MARin,
  output logic              MDRin,
  output logic              MDRout,
  output logic              IRin,
  output logic              Yin,
  output logic              Zlowin,
  output logic              Zhighin,
  output logic              Zlowout,
  output logic              Zhighout,
  output logic              HIin,
  output logic              LOin,
  output logic              IncPC,
  output logic              Read,
  output logic [ALUOP_W-1:0] ALUop,
  output logic              ALU_MUL,
  output logic              ALU_DIV,
  output logic              run
);

  decode_t      dec_c;
  state_t       state;
  state_t       state_nxt;
  instr_class_e cls_q;
  aluop_t       aluop_q;
  logic         mul_q;
  logic         div_q;

  instr_decoder #(.OPW(OPW)) u_instr_decoder (
    .IR    (IR),
    .dec_c (dec_c)
  );

  function automatic logic [NREGS-1:0] reg_sel(input reg_idx_t idx);
    return NREGS'(1) << idx;
  endfunction

  // State register; the decoded opcode is frozen when leaving T3.
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      state   <= S_RESET;
      cls_q   <= CLS_NOP;
      aluop_q <= ALU_ADD;
      mul_q   <= 1'b0;
      div_q   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == S_T3) begin
        cls_q   <= dec_c.cls;
        aluop_q <= dec_c.alu_op;
        mul_q   <= dec_c.mul;
        div_q   <= dec_c.div;
      end
    end
  end

  always_comb begin
    state_nxt = S_RESET;
    case (state)
      S_RESET: state_nxt = S_T0;
      S_T0:    state_nxt = S_T1;
      S_T1:    state_nxt = S_T2;
      S_T2:    state_nxt = S_T3;
      S_T3: begin
        case (dec_c.cls)
          CLS_HALT: state_nxt = S_HALT;
          CLS_NOP:  state_nxt = S_T0;
          default:  state_nxt = S_T4;
        endcase
      end
      S_T4:    state_nxt = (cls_q == CLS_UNARY) ? S_T0 : S_T5;
      S_T5:    state_nxt = (cls_q == CLS_MULDIV) ? S_T6 : S_T0;
      S_T6:    state_nxt = S_T0;
      S_HALT:  state_nxt = S_HALT;
      default: state_nxt = S_RESET;
    endcase
  end

  // Strobe decode: T0-T2 fetch, T3 from live decode, T4+ from the frozen opcode.
  always_comb begin
    Rin      = '0;
    Rout     = '0;
    PCin     = 1'b0;
    PCout    = 1'b0;
    MARin    = 1'b0;
    MDRin    = 1'b0;
    MDRout   = 1'b0;
    IRin     = 1'b0;
    Yin      = 1'b0;
    Zlowin   = 1'b0;
    Zhighin  = 1'b0;
    Zlowout  = 1'b0;
    Zhighout = 1'b0;
    HIin     = 1'b0;
    LOin     = 1'b0;
    IncPC    = 1'b0;
    Read     = 1'b0;
    ALUop    = ALU_ADD;
    ALU_MUL  = 1'b0;
    ALU_DIV  = 1'b0;
    run      = (state != S_RESET) && (state != S_HALT);
    case (state)
      S_T0: begin
        PCout  = 1'b1;
        MARin  = 1'b1;
        IncPC  = 1'b1;
        Zlowin = 1'b1;
      end
      S_T1: begin
        Zlowout = 1'b1;
        PCin    = 1'b1;
        Read    = 1'b1;
        MDRin   = 1'b1;
      end
      S_T2: begin
        MDRout = 1'b1;
        IRin   = 1'b1;
      end
      S_T3: begin
        case (dec_c.cls)
          CLS_ALU3: begin
            Rout = reg_sel(dec_c.rb);
            Yin  = 1'b1;
          end
          CLS_MULDIV: begin
            Rout = reg_sel(dec_c.ra);
            Yin  = 1'b1;
          end
          CLS_UNARY: begin
            Rout   = reg_sel(dec_c.rb);
            ALUop  = dec_c.alu_op;
            Zlowin = 1'b1;
          end
          default: ;
        endcase
      end
      S_T4: begin
        case (cls_q)
          CLS_ALU3: begin
            Rout   = reg_sel(dec_c.rc);
            ALUop  = aluop_q;
            Zlowin = 1'b1;
          end
          CLS_MULDIV: begin
            Rout    = reg_sel(dec_c.rb);
            ALU_MUL = mul_q;
            ALU_DIV = div_q;
            Zlowin  = 1'b1;
            Zhighin = 1'b1;
          end
          CLS_UNARY: begin
            Zlowout = 1'b1;
            Rin     = reg_sel(dec_c.ra);
          end
          default: ;
        endcase
      end
      S_T5: begin
        case (cls_q)
          CLS_ALU3: begin
            Zlowout = 1'b1;
            Rin     = reg_sel(dec_c.ra);
          end
          CLS_MULDIV: begin
            Zlowout = 1'b1;
            LOin    = 1'b1;
          end
          default: ;
        endcase
      end
      S_T6: begin
        if (cls_q == CLS_MULDIV) begin
          Zhighout = 1'b1;
          HIin     = 1'b1;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_alu_control_sequencer.sv
// Bench: sequencer driving a small behavioural datapath, checked every cycle
// against an instruction-level model plus hand-computed register results.
`timescale 1ns/1ps
module tb_alu_control_sequencer;

  localparam int PH_RESET = -1;
  localparam int PH_HALT  = 99;

  typedef struct packed {
    logic [15:0] rin;
    logic [15:0] rout;
    logic pcin, pcout, marin, mdrin, mdrout, irin, yin;
    logic zlowin, zhighin, zlowout, zhighout, hiin, loin, incpc, read;
    logic [3:0] aluop;
    logic amul, adiv, run;
  } ctl_t;

  logic        clock = 1'b0;
  logic        clear;
  logic [31:0] IR;
  logic [15:0] Rin, Rout;
  logic PCin, PCout, MARin, MDRin, MDRout, IRin, Yin;
  logic Zlowin, Zhighin, Zlowout, Zhighout, HIin, LOin, IncPC, Read;
  logic [3:0] ALUop;
  logic ALU_MUL, ALU_DIV, run;

  alu_control_sequencer #(.NREGS(16), .OPW(5)) dut (
    .clock(clock), .clear(clear), .IR(IR),
    .Rin(Rin), .Rout(Rout),
    .PCin(PCin), .PCout(PCout), .MARin(MARin), .MDRin(MDRin), .MDRout(MDRout),
    .IRin(IRin), .Yin(Yin),
    .Zlowin(Zlowin), .Zhighin(Zhighin), .Zlowout(Zlowout), .Zhighout(Zhighout),
    .HIin(HIin), .LOin(LOin), .IncPC(IncPC), .Read(Read),
    .ALUop(ALUop), .ALU_MUL(ALU_MUL), .ALU_DIV(ALU_DIV), .run(run)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  ctl_t act;
  assign act = {Rin, Rout, PCin, PCout, MARin, MDRin, MDRout, IRin, Yin,
                Zlowin, Zhighin, Zlowout, Zhighout, HIin, LOin, IncPC, Read,
                ALUop, ALU_MUL, ALU_DIV, run};

  // ---------------- behavioural datapath ----------------
  logic [31:0] regs [16];
  logic [31:0] init_vals [16];
  logic        load_regs;
  logic [31:0] mem [8];
  logic [31:0] pc, mar, mdr, y, hi, lo;
  logic [63:0] z;
  logic [31:0] bus;

  assign IR = ir_q;
  logic [31:0] ir_q;

  always_comb begin
    bus = '0;
    if (PCout)    bus = pc;
    if (MDRout)   bus = mdr;
    if (Zlowout)  bus = z[31:0];
    if (Zhighout) bus = z[63:32];
    for (int i = 0; i < 16; i++) if (Rout[i]) bus = regs[i];
  end

  function automatic logic [63:0] alu(input logic [3:0] op, input logic mul, input logic div,
                                      input logic inc, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r;
    if (inc) return {32'd0, b + 32'd1};
    if (mul) return 64'($signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b}));
    if (div) return (b == 0) ? 64'd0 : {32'($signed(a) % $signed(b)), 32'($signed(a) / $signed(b))};
    case (op)
      4'd0:  r = a + b;
      4'd1:  r = a - b;
      4'd2:  r = a & b;
      4'd3:  r = a | b;
      4'd4:  r = a >> b[4:0];
      4'd5:  r = a << b[4:0];
      4'd6:  r = 32'($signed(a) >>> b[4:0]);
      4'd7:  r = (a >> b[4:0]) | (a << (6'd32 - {1'b0, b[4:0]}));
      4'd8:  r = (a << b[4:0]) | (a >> (6'd32 - {1'b0, b[4:0]}));
      4'd9:  r = -b;
      4'd10: r = ~b;
      default: r = '0;
    endcase
    return {32'd0, r};
  endfunction

  always @(posedge clock or posedge clear) begin
    if (clear) pc <= '0;
    else if (PCin) pc <= bus;
  end

  always @(posedge clock) begin
    if (load_regs) for (int i = 0; i < 16; i++) regs[i] <= init_vals[i];
    for (int i = 0; i < 16; i++) if (Rin[i]) regs[i] <= bus;
    if (MARin) mar <= bus;
    if (MDRin && Read) mdr <= mem[mar[2:0]];
    if (IRin) ir_q <= bus;
    if (Yin) y <= bus;
    if (Zlowin || Zhighin) z <= alu(ALUop, ALU_MUL, ALU_DIV, IncPC, y, bus);
    if (LOin) lo <= bus;
    if (HIin) hi <= bus;
  end

  // ---------------- instruction-level model ----------------
  // class: 0 three-register ALU, 1 mul/div, 2 neg/not, 3 nop/illegal, 4 halt
  function automatic int cls_of(input logic [31:0] w);
    int op;
    op = int'(w[31:27]);
    if (op inside {[3:11]}) return 0;
    if (op == 15 || op == 16) return 1;
    if (op == 17 || op == 18) return 2;
    if (op == 27) return 4;
    return 3;
  endfunction

  function automatic int len_of(input int c);
    case (c)
      0: return 6;
      1: return 7;
      2: return 5;
      default: return 4;
    endcase
  endfunction

  function automatic logic [3:0] code_of(input logic [31:0] w);
    case (int'(w[31:27]))
      3: return 4'd0;   4: return 4'd1;   5: return 4'd2;   6: return 4'd3;
      7: return 4'd7;   8: return 4'd8;   9: return 4'd4;   10: return 4'd6;
      11: return 4'd5;  17: return 4'd9;  18: return 4'd10;
      default: return 4'd0;
    endcase
  endfunction

  function automatic ctl_t exp_ctl(input int ph, input logic [31:0] w);
    ctl_t e;
    int c;
    logic [15:0] ra_b, rb_b, rc_b;
    e = '0;
    c = cls_of(w);
    ra_b = 16'(1) << w[26:23];
    rb_b = 16'(1) << w[22:19];
    rc_b = 16'(1) << w[18:15];
    if (ph == PH_RESET || ph == PH_HALT) return e;
    e.run = 1'b1;
    case (ph)
      0: begin e.pcout = 1; e.marin = 1; e.incpc = 1; e.zlowin = 1; end
      1: begin e.zlowout = 1; e.pcin = 1; e.read = 1; e.mdrin = 1; end
      2: begin e.mdrout = 1; e.irin = 1; end
      3: begin
        if (c == 0) begin e.rout = rb_b; e.yin = 1; end
        if (c == 1) begin e.rout = ra_b; e.yin = 1; end
        if (c == 2) begin e.rout = rb_b; e.aluop = code_of(w); e.zlowin = 1; end
      end
      4: begin
        if (c == 0) begin e.rout = rc_b; e.aluop = code_of(w); e.zlowin = 1; end
        if (c == 1) begin
          e.rout = rb_b; e.amul = (w[31:27] == 5'd16); e.adiv = (w[31:27] == 5'd15);
          e.zlowin = 1; e.zhighin = 1;
        end
        if (c == 2) begin e.zlowout = 1; e.rin = ra_b; end
      end
      5: begin
        if (c == 0) begin e.zlowout = 1; e.rin = ra_b; end
        if (c == 1) begin e.zlowout = 1; e.loin = 1; end
      end
      6: if (c == 1) begin e.zhighout = 1; e.hiin = 1; end
      default: ;
    endcase
    return e;
  endfunction

  int          m_phase = PH_RESET;
  int          m_pc = 0;
  logic [31:0] m_word = '0;

  always @(posedge clock) begin
    if (clear) begin
      m_phase <= PH_RESET;
      m_pc    <= 0;
    end else if (m_phase == PH_RESET) begin
      m_phase <= 0;
    end else if (m_phase != PH_HALT) begin
      if (m_phase == 2) begin
        m_phase <= 3;
        m_word  <= mem[m_pc[2:0]];
        m_pc    <= m_pc + 1;
      end else if (m_phase == 3 && cls_of(m_word) == 4) begin
        m_phase <= PH_HALT;
      end else if (m_phase + 1 == len_of(cls_of(m_word))) begin
        m_phase <= 0;
      end else begin
        m_phase <= m_phase + 1;
      end
    end
  end

  always @(negedge clock) begin
    ctl_t e;
    e = clear ? ctl_t'('0) : exp_ctl(m_phase, m_word);
    check("cycle_strobes", 64'(act), 64'(e));
  end

  // ---------------- directed stimulus ----------------
  logic [15:0] tr_rin [8];
  logic [15:0] tr_rout [8];
  logic [3:0]  tr_aluop [8];

  // From a T0 sample, step to the next T0 and check the cycle count.
  task automatic run_instr(input string name, input int exp_len);
    int n;
    n = 0;
    for (int k = 0; k < 8; k++) begin tr_rin[k] = '0; tr_rout[k] = '0; tr_aluop[k] = '0; end
    do begin
      @(negedge clock);
      n++;
      if (n < 8) begin tr_rin[n] = Rin; tr_rout[n] = Rout; tr_aluop[n] = ALUop; end
    end while (!(PCout && MARin) && n < 20);
    check({"cpi_", name}, 64'(n), 64'(exp_len));
  endtask

  initial begin
    clear     = 1'b1;
    load_regs = 1'b1;
    for (int i = 0; i < 16; i++) init_vals[i] = '0;
    init_vals[0] = 32'hFFFF_FFF0;
    init_vals[1] = 32'd7;
    init_vals[3] = 32'd6;
    init_vals[4] = 32'd2;
    init_vals[5] = 32'd1;
    init_vals[6] = 32'h1234_5678;
    mem[0] = 32'h5382_0000;  // shra R7,R0,R4
    mem[1] = 32'h8188_0000;  // mul  R3,R1
    mem[2] = 32'h8928_0000;  // neg  R2,R5
    mem[3] = 32'hF800_0000;  // illegal opcode 31
    mem[4] = 32'hD800_0000;  // halt
    for (int i = 5; i < 8; i++) mem[i] = 32'hD800_0000;

    @(negedge clock);
    #2 load_regs = 1'b0;
    repeat (2) @(negedge clock);
    check("reset_outputs", 64'(act), 64'd0);
    check("reset_run", 64'(run), 64'd0);
    #2 clear = 1'b0;
    @(negedge clock);
    check("first_t0", 64'({PCout, MARin, IncPC}), 64'h7);

    run_instr("shra", 6);
    check("shra_t3_rout", 64'(tr_rout[3]), 64'h0001);
    check("shra_t4_rout", 64'(tr_rout[4]), 64'h0010);
    check("shra_t4_aluop", 64'(tr_aluop[4]), 64'd6);
    check("shra_t5_rin", 64'(tr_rin[5]), 64'h0080);
    check("shra_r7", 64'(regs[7]), 64'hFFFF_FFFC);

    run_instr("mul", 7);
    check("mul_lo", 64'(lo), 64'd42);
    check("mul_hi", 64'(hi), 64'd0);

    run_instr("neg", 5);
    check("neg_r2", 64'(regs[2]), 64'hFFFF_FFFF);

    run_instr("illegal", 4);
    check("illegal_t3_rin", 64'(tr_rin[3]), 64'd0);
    check("illegal_t3_rout", 64'(tr_rout[3]), 64'd0);
    check("illegal_r7_kept", 64'(regs[7]), 64'hFFFF_FFFC);

    repeat (3) @(negedge clock);
    for (int k = 0; k < 10; k++) begin
      @(negedge clock);
      check("halt_strobes", 64'(act), 64'd0);
    end

    // Restart with an add and abort it in T4.
    #2 clear = 1'b1;
    mem[0] = 32'h1B09_0000;  // add R6,R1,R2
    @(negedge clock);
    #2 clear = 1'b0;
    @(negedge clock);
    check("restart_t0", 64'({PCout, MARin, IncPC}), 64'h7);
    repeat (4) @(negedge clock);
    check("add_t4_rout", 64'(Rout), 64'h0004);
    #1 clear = 1'b1;
    #1 check("async_clear_outputs", 64'(act), 64'd0);
    check("async_clear_r6", 64'(regs[6]), 64'h1234_5678);
    @(negedge clock);
    #2 clear = 1'b0;
    @(negedge clock);
    check("post_clear_t0", 64'({PCout, MARin, IncPC}), 64'h7);
    check("post_clear_r6", 64'(regs[6]), 64'h1234_5678);
    run_instr("add", 6);
    check("add_r6", 64'(regs[6]), 64'd6);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
